// File: rtl/seven_seg_defs_pkg.sv
// seven_seg_defs_pkg: shared display definitions (scan states, nibble width, width helper)
package seven_seg_defs_pkg;
    localparam int NIB_W = 4;
    typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} scan_state_e;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/seven_seg_scan_timer.sv
// seven_seg_scan_timer: per-slot cycle counter and digit index with explicit wrap
module seven_seg_scan_timer
    import seven_seg_defs_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2,
    localparam int CW = clog2(REFRESH_DIV),
    localparam int IW = clog2(NUM_DIGITS)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [IW-1:0] idx_o,
    output logic [IW-1:0] idx_nxt_o,
    output logic          slot_last_o,
    output logic          blank_last_o,
    output logic          pre_last_o,
    output logic          frame_wrap_o
);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    assign slot_last_o  = cnt_q == CW'(REFRESH_DIV - 1);
    assign blank_last_o = cnt_q == CW'(BLANK_CYCLES - 1);
    assign pre_last_o   = cnt_q == CW'(REFRESH_DIV - 2);
    assign frame_wrap_o = slot_last_o && idx_q == IW'(NUM_DIGITS - 1);
    assign idx_o        = idx_q;
    assign idx_nxt_o    = idx_d;
    always_comb begin
        cnt_d = slot_last_o ? '0 : cnt_q + 1'b1;
        idx_d = frame_wrap_o ? '0 : slot_last_o ? idx_q + 1'b1 : idx_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: multiplexed digit scanner with blanking, leading-zero suppression and tear-free updates
module seven_seg_scan_ctrl
    import seven_seg_defs_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NIB_W*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]         dots,
    input  logic                          load,
    input  logic                          lz_en,
    output logic [NIB_W-1:0]              hex_out,
    output logic                          dot_out,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic                          frame_done
);
    localparam int IW = clog2(NUM_DIGITS);
    localparam int VW = NIB_W * NUM_DIGITS;
    scan_state_e           state_q, state_d;
    logic [IW-1:0]         idx, idx_nxt;
    logic                  slot_last, blank_last, pre_last, frame_wrap;
    logic [VW-1:0]         pend_val_q, shadow_val_q;
    logic [NUM_DIGITS-1:0] pend_dots_q, shadow_dots_q;
    logic [NUM_DIGITS-1:0] sup, digit_en_d;
    logic [NIB_W-1:0]      hex_d;
    logic                  zero_hi, on, dot_d, frame_done_d;

    seven_seg_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .idx_o       (idx),
        .idx_nxt_o   (idx_nxt),
        .slot_last_o (slot_last),
        .blank_last_o(blank_last),
        .pre_last_o  (pre_last),
        .frame_wrap_o(frame_wrap)
    );

    // A digit is blanked when it and every more-significant nibble are zero and it carries no dot
    always_comb begin
        zero_hi = 1'b1;
        sup     = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_hi = zero_hi && shadow_val_q[i*NIB_W +: NIB_W] == '0;
            sup[i]  = lz_en && zero_hi && !shadow_dots_q[i];
        end
    end

    // Outputs are computed from next-cycle state so they switch on the same edge as state/idx
    always_comb begin
        state_d      = state_q == ST_BLANK ? (blank_last ? ST_DRIVE : ST_BLANK)
                                           : (slot_last ? ST_BLANK : ST_DRIVE);
        on           = state_d == ST_DRIVE && !sup[idx_nxt];
        digit_en_d   = on ? NUM_DIGITS'(1) << idx_nxt : '0;
        hex_d        = on ? shadow_val_q[idx_nxt*NIB_W +: NIB_W] : '0;
        dot_d        = on && shadow_dots_q[idx_nxt];
        frame_done_d = pre_last && idx == IW'(NUM_DIGITS - 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_BLANK;
            pend_val_q    <= '0;
            pend_dots_q   <= '0;
            shadow_val_q  <= '0;
            shadow_dots_q <= '0;
            hex_out       <= '0;
            dot_out       <= 1'b0;
            digit_en      <= '0;
            frame_done    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hex_out    <= hex_d;
            dot_out    <= dot_d;
            digit_en   <= digit_en_d;
            frame_done <= frame_done_d;
            if (load) begin
                pend_val_q  <= value;
                pend_dots_q <= dots;
            end
            if (frame_wrap) begin
                shadow_val_q  <= load ? value : pend_val_q;
                shadow_dots_q <= load ? dots : pend_dots_q;
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: table-driven frame checks plus mid-frame load and mid-slot reset sequences
module tb_seven_seg_scan_ctrl;
    typedef struct {
        logic [15:0] val;
        logic [3:0]  dots;
        logic        lz;
        logic [3:0]  drv;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dots = '0;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [3:0]  hex_out;
    logic        dot_out;
    logic [3:0]  digit_en;
    logic        frame_done;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          fr = 0;
    rec_t        tbl[8];
    rec_t        zr, abcd, r5555, r9876;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .dots      (dots),
        .load      (load),
        .lz_en     (lz_en),
        .hex_out   (hex_out),
        .dot_out   (dot_out),
        .digit_en  (digit_en),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got en=%b hex=%h dot=%b fd=%b, expected en=%b hex=%h dot=%b fd=%b",
                     name, got[9:6], got[5:2], got[1], got[0], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    // Checks cycles 0..last of a frame displaying e; optional loads at cycles ca and cb
    task automatic frame(input rec_t e, input int last, input int ca, input rec_t la,
                         input int cb, input rec_t lb);
        for (int c = 0; c <= last; c++) begin
            int          ix;
            logic        on;
            logic [9:0]  exp;
            ix  = c / 8;
            on  = (c % 8) >= 2 && e.drv[ix];
            exp = {on ? 4'(1 << ix) : 4'd0, on ? e.val[ix*4 +: 4] : 4'd0, on && e.dots[ix], c == 31};
            check($sformatf("frame%0d cyc%0d", fr, c), {digit_en, hex_out, dot_out, frame_done}, exp);
            lz_en = e.lz;
            load  = c == ca || c == cb;
            value = c == cb ? lb.val : la.val;
            dots  = c == cb ? lb.dots : la.dots;
            @(negedge clk);
        end
        load = 1'b0;
        fr++;
    endtask

    initial begin
        tbl[0] = '{16'h1234, 4'b0000, 1'b0, 4'b1111};
        tbl[1] = '{16'h0070, 4'b0000, 1'b1, 4'b0011};
        tbl[2] = '{16'h0070, 4'b0100, 1'b1, 4'b0111};
        tbl[3] = '{16'h0000, 4'b0000, 1'b1, 4'b0001};
        tbl[4] = '{16'h0000, 4'b0000, 1'b0, 4'b1111};
        tbl[5] = '{16'h0A00, 4'b0000, 1'b1, 4'b0111};
        tbl[6] = '{16'h8000, 4'b0001, 1'b1, 4'b1111};
        tbl[7] = '{16'h0000, 4'b1000, 1'b1, 4'b1001};
        zr     = '{16'h0000, 4'b0000, 1'b0, 4'b1111};
        abcd   = '{16'hABCD, 4'b0000, 1'b0, 4'b1111};
        r5555  = '{16'h5555, 4'b0000, 1'b0, 4'b1111};
        r9876  = '{16'h9876, 4'b0000, 1'b0, 4'b1111};
        repeat (3) @(negedge clk);
        check("reset values", {digit_en, hex_out, dot_out, frame_done}, 10'd0);
        reset = 1'b0;
        frame(zr, 31, 0, tbl[0], -1, zr);
        for (int k = 0; k < 7; k++) frame(tbl[k], 31, 0, tbl[k+1], -1, zr);
        frame(tbl[7], 31, 10, abcd, -1, zr);
        frame(abcd, 31, 3, r5555, 31, r9876);
        frame(r9876, 12, -1, zr, -1, zr);
        check("digit1 drive before reset", {digit_en, hex_out, dot_out, frame_done}, {4'b0010, 4'h7, 1'b0, 1'b0});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("outputs after mid-slot reset", {digit_en, hex_out, dot_out, frame_done}, 10'd0);
        frame(zr, 31, -1, zr, -1, zr);
        frame(zr, 31, -1, zr, -1, zr);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
